// File: rtl/seq_match_logger.sv
// Timestamp logger for pattern-detector matches: stamps each z pulse into a
// show-ahead FIFO and keeps saturating match/drop counters plus a sticky overflow flag.
module seq_match_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             z,
    input  logic             clr,
    output logic             ts_valid,
    output logic [TS_W-1:0]  ts_data,
    input  logic             ts_ready,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [TS_W-1:0]  cyc_q, cyc_d;
    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [TS_W-1:0]  mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic full, pop, push, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        full = (cnt_q == FULL_CNT);
        pop  = valid_q && ts_ready;
        // A full FIFO still accepts a push when the head is leaving on the same edge.
        push = z && (!full || pop);
        drop = z && full && !pop;

        cyc_d   = cyc_q + TS_W'(1);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        match_d = match_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;

        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            match_d = '0;
            drop_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = cyc_q;
                wptr_d        = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
            if (z) begin
                match_d = sat_inc(match_q);
            end
            if (drop) begin
                drop_d = sat_inc(drop_q);
                ovf_d  = 1'b1;
            end
        end

        valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            match_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cyc_q   <= cyc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            match_q <= match_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign ts_valid    = valid_q;
    assign ts_data     = mem_q[rptr_q];
    assign match_count = match_q;
    assign drop_count  = drop_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// Bench for seq_match_logger: a wide instance and a narrow (TS_W=4, CNT_W=3)
// instance share stimulus and are compared against a queue-based model.
module tb_seq_match_logger;

    logic clk;
    logic rst;
    logic z;
    logic clr;
    logic ts_ready;

    logic        tv_a;
    logic [15:0] td_a;
    logic [7:0]  mc_a;
    logic [7:0]  dc_a;
    logic        ov_a;

    logic        tv_b;
    logic [3:0]  td_b;
    logic [2:0]  mc_b;
    logic [2:0]  dc_b;
    logic        ov_b;

    seq_match_logger #(.TS_W(16), .DEPTH(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .z(z), .clr(clr),
        .ts_valid(tv_a), .ts_data(td_a), .ts_ready(ts_ready),
        .match_count(mc_a), .drop_count(dc_a), .overflow(ov_a)
    );

    seq_match_logger #(.TS_W(4), .DEPTH(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .z(z), .clr(clr),
        .ts_valid(tv_b), .ts_data(td_b), .ts_ready(ts_ready),
        .match_count(mc_b), .drop_count(dc_b), .overflow(ov_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: cycle number since reset, stored stamps, raw counts.
    int cyc;
    int q[$];
    int m;
    int d;
    int ov;

    int nchk;
    int nerr;

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a_valid", int'(tv_a), int'(q.size() > 0));
        chk("b_valid", int'(tv_b), int'(q.size() > 0));
        if (q.size() > 0) begin
            chk("a_data", int'(td_a), q[0] & 'hFFFF);
            chk("b_data", int'(td_b), q[0] & 'hF);
        end
        chk("a_match", int'(mc_a), sat(m, 8));
        chk("b_match", int'(mc_b), sat(m, 3));
        chk("a_drop", int'(dc_a), sat(d, 8));
        chk("b_drop", int'(dc_b), sat(d, 3));
        chk("a_ovf", int'(ov_a), ov);
        chk("b_ovf", int'(ov_b), ov);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_valid"}, int'(tv_a), 0);
        chk({tag, "_a_data"},  int'(td_a), 0);
        chk({tag, "_a_match"}, int'(mc_a), 0);
        chk({tag, "_a_drop"},  int'(dc_a), 0);
        chk({tag, "_a_ovf"},   int'(ov_a), 0);
        chk({tag, "_b_valid"}, int'(tv_b), 0);
        chk({tag, "_b_data"},  int'(td_b), 0);
        chk({tag, "_b_match"}, int'(mc_b), 0);
    endtask

    // Called one time unit after a rising edge; asserts rst mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        q.delete();
        cyc = 0;
        m   = 0;
        d   = 0;
        ov  = 0;
        @(posedge clk);
        #1;
        chk_zero("rst_held");
        z        = 1'b0;
        clr      = 1'b0;
        ts_ready = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic step(input bit zi, input bit ri, input bit ci);
        bit pop;
        bit full;
        z        = zi;
        ts_ready = ri;
        clr      = ci;
        if (ci) begin
            q.delete();
            m  = 0;
            d  = 0;
            ov = 0;
        end else begin
            pop  = (q.size() > 0) && ri;
            full = (q.size() == 4);
            if (pop) void'(q.pop_front());
            if (zi) begin
                m++;
                if (!full || pop) q.push_back(cyc);
                else begin
                    d++;
                    ov = 1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        nchk     = 0;
        nerr     = 0;
        rst      = 1'b1;
        z        = 1'b0;
        clr      = 1'b0;
        ts_ready = 1'b0;
        cyc      = 0;
        m        = 0;
        d        = 0;
        ov       = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Basic capture at edges 3 and 7, then drain.
        for (int i = 0; i < 8; i++) step(i == 3 || i == 7, 1'b0, 1'b0);
        chk("lit_cap_valid", int'(tv_a), 1);
        chk("lit_cap_data", int'(td_a), 3);
        chk("lit_cap_match", int'(mc_a), 2);
        chk("lit_cap_ovf", int'(ov_a), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_drain_data", int'(td_a), 7);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_drain_empty", int'(tv_a), 0);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_drain_idle", int'(tv_a), 0);

        // Overflow, full push+pop, clear priority.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 10; i < 16; i++) step(1'b1, 1'b0, 1'b0);
        chk("lit_ovf_head", int'(td_a), 10);
        chk("lit_ovf_drop", int'(dc_a), 2);
        chk("lit_ovf_flag", int'(ov_a), 1);
        chk("lit_ovf_match", int'(mc_a), 6);
        for (int i = 16; i < 20; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("lit_fullpp_head", int'(td_a), 11);
        chk("lit_fullpp_drop", int'(dc_a), 2);
        step(1'b1, 1'b0, 1'b1);
        chk("lit_clr_valid", int'(tv_a), 0);
        chk("lit_clr_match", int'(mc_a), 0);
        chk("lit_clr_ovf", int'(ov_a), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_post_clr_stamp", int'(td_a), 22);

        // Narrow timestamp wrap and narrow counter saturation.
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("lit_wrap_15", int'(td_b), 15);
        step(1'b0, 1'b1, 1'b0);
        chk("lit_wrap_0", int'(td_b), 0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
        chk("lit_sat_b", int'(mc_b), 7);
        chk("lit_sat_a", int'(mc_a), 9);
        do_reset();

        // Randomised traffic with occasional clears and mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                z = ($urandom_range(0, 1) == 1);
                do_reset();
            end else begin
                step($urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < 4,
                     $urandom_range(0, 29) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
